piso_bit_feeder: RTL
====================

# piso_bit_feeder

Parallel-in/serial-out feeder that accepts words over a valid/ready handshake and emits them one bit at a time on `x`. It sits directly upstream of the Moore 1010 sequence detector and drives that detector's serial `x` input. A one-word holding buffer lets consecutive words stream with no gap between them. A per-bit hold divider sets the serial bit rate.

## Interface
- `WIDTH`, default 8: word width in bits, legal range 2..32.
- `DIV`, default 1: clock cycles each bit is held on `x`, must be ≥1.
- `MSB_FIRST`, default 1: 1 sends `din[WIDTH-1]` first; 0 sends `din[0]` first.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  parallel word to serialize.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept a word this cycle.
- `x`  out  1  serial bit; 0 whenever `x_valid`=0.
- `x_valid`  out  1  `x` carries a word bit.
- `busy`  out  1  shifting a word (state SHIFT).
- `word_done`  out  1  one-cycle pulse on the final cycle of each word's last bit.

## Operation
- **Reset.** With `rst`=1 at an edge, outputs are cleared next cycle to: `x`=0, `x_valid`=0, `busy`=0, `word_done`=0, `din_ready`=1. Shift register, holding buffer, bit counter and divider counter are all cleared. `rst` overrides all other inputs.
- **Transfer.** A word transfers on an edge where `din_valid`=1 and `din_ready`=1. `din` is ignored when `din_ready`=0.
- **`din_ready`.** Equals NOT (holding buffer full), decoded from registered state only. It has no combinational path from `din_valid`.
- **States.** The FSM has two states, IDLE and SHIFT.
  - IDLE: a transfer loads `din` straight into the shift register, clears `bit_idx` and `div_cnt`, and moves to SHIFT.
  - SHIFT, `div_cnt` < DIV-1: increment `div_cnt`.
  - SHIFT, `div_cnt` = DIV-1 and `bit_idx` < WIDTH-1: clear `div_cnt`, increment `bit_idx`, advance to the next bit in `MSB_FIRST` order.
  - SHIFT, `div_cnt` = DIV-1 and `bit_idx` = WIDTH-1 (end of word), in priority order:
    1. Holding buffer full: load it into the shift register, mark the buffer empty, stay in SHIFT.
    2. Otherwise, a transfer on this edge: load `din` directly into the shift register, stay in SHIFT.
    3. Otherwise: go to IDLE.
- **Holding buffer fill.** A transfer in SHIFT that is not an end-of-word edge writes `din` into the holding buffer and marks it full.
- **Output decode.**
  - `x_valid` = `busy` = (state == SHIFT).
  - `x` = current bit when in SHIFT, else 0.
  - `word_done` = SHIFT && `bit_idx`==WIDTH-1 && `div_cnt`==DIV-1.
- **Counter widths.**
  - `bit_idx` is clog2(WIDTH) bits and never exceeds WIDTH-1.
  - `div_cnt` is clog2(DIV) bits, minimum 1, and is constant 0 when DIV=1.
- **Reset mid-word.** The partial word and any held word are discarded. No `word_done` pulse is produced for either.

## Timing
- **Latency.** A transfer at edge N puts the first bit on `x` with `x_valid`=1 during cycle N+1.
- **Word duration.** Each word occupies exactly WIDTH×DIV cycles of `x_valid`=1.
- **Throughput.** Back-to-back words are gapless, provided the next word is held or offered by the end-of-word edge. Otherwise `x_valid` drops for at least one cycle.
- **`din_ready` timing.**
  - Falls the cycle after the holding buffer fills.
  - Rises the cycle after the buffer drains at the end-of-word edge.
  - Stays continuously 1 while in IDLE.
- **`word_done`.** Asserted for exactly one cycle per word. With DIV=1 it coincides with the last bit.

## Test plan
1. **Reset values.** Assert `rst` for 2 cycles with `din_valid`=1 and `din`=8'hFF. Required: `x`=0, `x_valid`=0, `busy`=0, `word_done`=0, `din_ready`=1 throughout, and no transfer.
2. **Single word.** WIDTH=8, DIV=1, MSB_FIRST=1, `din`=8'hA5 transferred at edge 0. Required: `x_valid`=1 in cycles 1–8; `x`=1,0,1,0,0,1,0,1; `word_done` only in cycle 8; `x_valid`=0 from cycle 9; `din_ready`=1 throughout.
3. **Back-to-back with buffer.** Transfer 8'hA0 at edge 0, then 8'h5A offered from cycle 1 with `din_valid` held. Required: 8'h5A accepted at edge 1; `din_ready`=0 in cycles 2–8, 1 from cycle 9; `x_valid`=1 continuously in cycles 1–16; 8'h5A bits (0,1,0,1,1,0,1,0) in cycles 9–16; `word_done` in cycles 8 and 16.
4. **Divider and LSB-first.** DIV=3, MSB_FIRST=0, `din`=8'h01. Required: `x`=1 in cycles 1–3 and 0 in cycles 4–24; `x_valid`=1 in cycles 1–24; a single `word_done` in cycle 24.
5. **Simultaneous end-of-word transfer.** DIV=1, holding buffer empty, 8'h0F offered only on the edge ending cycle 8. Required: accepted directly into the shift register; `x_valid` stays 1 in cycle 9 with `x`=0; `din_ready` never drops.
6. **Reset mid-word.** Apply `rst` during bit 4 of a word with the holding buffer full. Required: reset values in the next cycle and no `word_done`. A following word 8'hA5 then serializes exactly as in scenario 2.

Source files
------------

// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out feeder with a one-word holding buffer and a per-bit hold divider.
// Feeds the serial x input of a downstream 1010 sequence detector.
module piso_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] hold_r;
    logic             hold_full_r;
    logic [BIT_W-1:0] bit_idx_r;
    logic [DIV_W-1:0] div_cnt_r;

    logic transfer_s;
    logic div_end_s;
    logic last_bit_s;
    logic eow_s;

    // Moves the next bit into the output position in the configured bit order.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) begin
            return {w[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, w[WIDTH-1:1]};
        end
    endfunction

    // Handshake and end-of-word decode from registered state only.
    always_comb begin
        transfer_s = din_valid && !hold_full_r;
        div_end_s  = (div_cnt_r == DIV_LAST);
        last_bit_s = (bit_idx_r == LAST_IDX);
        eow_s      = (state_r == SHIFT) && div_end_s && last_bit_s;
    end

    // Output decode; x is forced low whenever no word bit is presented.
    always_comb begin
        din_ready = !hold_full_r;
        x_valid   = (state_r == SHIFT);
        busy      = (state_r == SHIFT);
        word_done = eow_s;
        if (state_r == SHIFT) begin
            x = (MSB_FIRST != 0) ? shift_r[WIDTH-1] : shift_r[0];
        end else begin
            x = 1'b0;
        end
    end

    // Serializer FSM, bit/divider counters and holding buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            shift_r     <= '0;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            bit_idx_r   <= '0;
            div_cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (transfer_s) begin
                        shift_r   <= din;
                        bit_idx_r <= '0;
                        div_cnt_r <= '0;
                        state_r   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!div_end_s) begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end else if (!last_bit_s) begin
                        div_cnt_r <= '0;
                        bit_idx_r <= bit_idx_r + BIT_W'(1);
                        shift_r   <= advance(shift_r);
                    end else begin
                        // End of word: a held word wins over a word offered on this edge.
                        div_cnt_r <= '0;
                        bit_idx_r <= '0;
                        if (hold_full_r) begin
                            shift_r     <= hold_r;
                            hold_full_r <= 1'b0;
                        end else if (transfer_s) begin
                            shift_r <= din;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    if (transfer_s && !eow_s) begin
                        hold_r      <= din;
                        hold_full_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
